fetch_unit: RTL

- Instruction-fetch stage of the LC-3b pipeline. Owns the PC and the instruction-memory read handshake, and drives the IF/ID pipeline register.
- Consumes the combinational static branch predictor that sits in decode and evaluates ifid_ir/ifid_pc, plus mispredict redirects from EX.
- Contains a one-entry hold buffer and a drain FSM so that an outstanding memory read is never abandoned.

---
 rtl/fetch_unit_pkg.sv | 31 +++
 rtl/fetch_unit_if.sv | 30 +++
 rtl/fetch_ctrl.sv | 102 ++++++++++
 rtl/fetch_unit.sv | 118 +++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared LC-3b types for the fetch stage.
//   lc3b_word     : 16-bit machine word (addresses and instructions)
//   fetch_state_t : fetch FSM states
//   ifid_t        : IF/ID pipeline register contents (also the hold-buffer layout)
//   pc_sel_t      : next-PC source chosen by fetch_ctrl
package lc3b_types;

  typedef logic [15:0] lc3b_word;

  typedef enum logic [1:0] {
    FETCH,
    DRAIN,
    HOLD
  } fetch_state_t;

  typedef struct packed {
    logic     valid;
    lc3b_word ir;
    lc3b_word pc;
  } ifid_t;

  typedef enum logic [1:0] {
    PcKeep,
    PcInc,
    PcTarget,
    PcPend
  } pc_sel_t;

  localparam lc3b_word PcStep = 16'd2;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory read bus between the fetch stage and instruction memory.
//   imem_read    : read request, held until imem_resp
//   imem_address : fetch address
//   imem_resp    : one-cycle read-complete strobe
//   imem_rdata   : instruction word, valid with imem_resp
// master = fetch side, slave = memory side.
interface fetch_unit_if
  import lc3b_types::*;
();

  logic     imem_read;
  lc3b_word imem_address;
  logic     imem_resp;
  lc3b_word imem_rdata;

  modport master (
    output imem_read,
    output imem_address,
    input  imem_resp,
    input  imem_rdata
  );

  modport slave (
    input  imem_read,
    input  imem_address,
    output imem_resp,
    output imem_rdata
  );

endinterface

// File: rtl/fetch_ctrl.sv
// Fetch FSM: decides when to request memory, where the next PC comes from, and
// which IF/ID / hold-buffer / pending-target updates happen this cycle.
// Inputs : clk_i, rst_ni (synchronous, active-low), imem_resp_i, redirect_valid_i,
//          sel_branch_predict_i, stall_i, ifid_valid_i
// Outputs: imem_read_o, pc_sel_o, ifid_load_mem_o (IF/ID <= memory data),
//          ifid_load_hold_o (IF/ID <= hold buffer), ifid_clear_o, hold_load_o,
//          pend_load_o (pend_target <= current redirect target)
module fetch_ctrl
  import lc3b_types::*;
(
  input  logic    clk_i,
  input  logic    rst_ni,
  input  logic    imem_resp_i,
  input  logic    redirect_valid_i,
  input  logic    sel_branch_predict_i,
  input  logic    stall_i,
  input  logic    ifid_valid_i,
  output logic    imem_read_o,
  output pc_sel_t pc_sel_o,
  output logic    ifid_load_mem_o,
  output logic    ifid_load_hold_o,
  output logic    ifid_clear_o,
  output logic    hold_load_o,
  output logic    pend_load_o
);

  fetch_state_t state_q, state_d;
  logic adv, pred, redir, slot_free, read_req;

  // Decode consumes IF/ID this cycle. The predictor only counts on a consume so a
  // stalled branch sitting in IF/ID cannot redirect twice.
  assign adv       = ifid_valid_i & ~stall_i;
  assign pred      = adv & sel_branch_predict_i;
  assign redir     = redirect_valid_i | pred;
  assign slot_free = ~ifid_valid_i | adv;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    read_req         = 1'b0;
    pc_sel_o         = PcKeep;
    ifid_load_mem_o  = 1'b0;
    ifid_load_hold_o = 1'b0;
    hold_load_o      = 1'b0;
    pend_load_o      = 1'b0;

    unique case (state_q)
      FETCH: begin
        read_req = 1'b1;
        if (imem_resp_i) begin
          if (redir) begin
            pc_sel_o = PcTarget;
          end else if (slot_free) begin
            ifid_load_mem_o = 1'b1;
            pc_sel_o        = PcInc;
          end else begin
            hold_load_o = 1'b1;
            pc_sel_o    = PcInc;
            state_d     = HOLD;
          end
        end else if (redir) begin
          // Read is in flight: remember where to go and wait for it to finish.
          pend_load_o = 1'b1;
          state_d     = DRAIN;
        end
      end
      DRAIN: begin
        read_req = 1'b1;
        if (redirect_valid_i) begin
          pend_load_o = 1'b1;
        end
        if (imem_resp_i) begin
          pc_sel_o = PcPend;
          state_d  = FETCH;
        end
      end
      HOLD: begin
        if (redir) begin
          pc_sel_o = PcTarget;
          state_d  = FETCH;
        end else if (slot_free) begin
          ifid_load_hold_o = 1'b1;
          state_d          = FETCH;
        end
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  assign ifid_clear_o = redirect_valid_i | (adv & ~ifid_load_mem_o & ~ifid_load_hold_o);
  assign imem_read_o  = read_req & rst_ni;

endmodule

// File: rtl/fetch_unit.sv
// LC-3b instruction-fetch stage. Owns the PC, the instruction-memory read handshake,
// a one-entry hold buffer and the IF/ID register. Never abandons an outstanding read.
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   imem                : instruction-memory bus (master side)
//   stall_in            : decode cannot accept IF/ID this cycle
//   redirect_valid/pc   : EX mispredict redirect (highest priority)
//   sel_branch_predict  : static predictor fires on the IF/ID instruction
//   branch_target       : predicted target
//   ifid_valid/ir/pc    : IF/ID register (pc is fetch address + 2)
module fetch_unit
  import lc3b_types::*;
#(
  parameter lc3b_word RESET_PC = 16'h0000
) (
  input  logic            clk,
  input  logic            rst_n,
  fetch_unit_if.master    imem,
  input  logic            stall_in,
  input  logic            redirect_valid,
  input  lc3b_word        redirect_pc,
  input  logic            sel_branch_predict,
  input  lc3b_word        branch_target,
  output logic            ifid_valid,
  output lc3b_word        ifid_ir,
  output lc3b_word        ifid_pc
);

  lc3b_word pc_q, pc_d, pc_inc, target;
  lc3b_word pend_q, pend_d;
  ifid_t    ifid_q, ifid_d;
  ifid_t    hold_q, hold_d;

  pc_sel_t pc_sel;
  logic    ifid_load_mem, ifid_load_hold, ifid_clear, hold_load, pend_load;
  logic    imem_read;

  fetch_ctrl u_fetch_ctrl (
    .clk_i                (clk),
    .rst_ni               (rst_n),
    .imem_resp_i          (imem.imem_resp),
    .redirect_valid_i     (redirect_valid),
    .sel_branch_predict_i (sel_branch_predict),
    .stall_i              (stall_in),
    .ifid_valid_i         (ifid_q.valid),
    .imem_read_o          (imem_read),
    .pc_sel_o             (pc_sel),
    .ifid_load_mem_o      (ifid_load_mem),
    .ifid_load_hold_o     (ifid_load_hold),
    .ifid_clear_o         (ifid_clear),
    .hold_load_o          (hold_load),
    .pend_load_o          (pend_load)
  );

  // 16-bit modulo: 0xFFFE wraps to 0x0000.
  assign pc_inc = pc_q + PcStep;
  assign target = redirect_valid ? redirect_pc : branch_target;

  always_comb begin
    pc_d = pc_q;
    unique case (pc_sel)
      PcKeep:   pc_d = pc_q;
      PcInc:    pc_d = pc_inc;
      PcTarget: pc_d = target;
      PcPend:   pc_d = redirect_valid ? redirect_pc : pend_q;
    endcase
  end

  always_comb begin
    pend_d = pend_q;
    if (pend_load) begin
      pend_d = target;
    end
  end

  always_comb begin
    hold_d = hold_q;
    if (hold_load) begin
      hold_d = '{valid: 1'b1, ir: imem.imem_rdata, pc: pc_inc};
    end else if (ifid_load_hold || (pc_sel == PcTarget)) begin
      hold_d.valid = 1'b0;
    end
  end

  // Redirect clears regardless of any load; ctrl never loads while redirecting.
  always_comb begin
    ifid_d = ifid_q;
    if (ifid_clear) begin
      ifid_d.valid = 1'b0;
    end else if (ifid_load_mem) begin
      ifid_d = '{valid: 1'b1, ir: imem.imem_rdata, pc: pc_inc};
    end else if (ifid_load_hold) begin
      ifid_d = hold_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q   <= RESET_PC;
      pend_q <= '0;
      ifid_q <= '0;
      hold_q <= '0;
    end else begin
      pc_q   <= pc_d;
      pend_q <= pend_d;
      ifid_q <= ifid_d;
      hold_q <= hold_d;
    end
  end

  assign imem.imem_read    = imem_read;
  assign imem.imem_address = pc_q;

  assign ifid_valid = ifid_q.valid;
  assign ifid_ir    = ifid_q.ir;
  assign ifid_pc    = ifid_q.pc;

endmodule
